// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: debounced start/pause, game FSM, lives/wave tracking and screen timers
module game_flow_ctrl #(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int INTERLUDE_CYCLES    = 33000000,
  parameter int OVER_MIN_CYCLES     = 16500000,
  parameter int OVER_TIMEOUT_CYCLES = 330000000,
  parameter int LIVES_INIT          = 3,
  parameter int MAX_WAVE            = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] buttons,
  input  logic [2:0] game_status,
  output logic [2:0] game_state,
  output logic       interlude,
  output logic       new_game,
  output logic       new_wave,
  output logic [1:0] lives,
  output logic [3:0] wave
);
  localparam int T_TOP = (OVER_TIMEOUT_CYCLES > INTERLUDE_CYCLES) ? OVER_TIMEOUT_CYCLES : INTERLUDE_CYCLES;
  localparam int TW = $clog2(T_TOP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] T_SAT  = TW'(T_TOP);
  localparam logic [TW-1:0] T_INT  = TW'(INTERLUDE_CYCLES - 1);
  localparam logic [TW-1:0] T_MIN  = TW'(OVER_MIN_CYCLES);
  localparam logic [TW-1:0] T_OUT  = TW'(OVER_TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_PAUSE, S_INTER, S_OVER} state_t;
  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [1:0]          stab_q, stab_d, raw, press;
  logic [1:0][DW-1:0]  cnt_q, cnt_d;
  logic [2:0]          game_state_q, game_state_d;
  logic                interlude_q, interlude_d, new_game_q, new_game_d, new_wave_q, new_wave_d;
  logic                pend_q, pend_d;
  logic [1:0]          lives_q, lives_d;
  logic [3:0]          wave_q, wave_d;
  logic                start_p, pause_p, unused_ok;
  assign raw = {buttons[3], buttons[1]};
  assign unused_ok = ^{buttons[4], buttons[2], buttons[0]};
  assign start_p = press[0];
  assign pause_p = press[1];
  // debounce: the stable level flips after DEBOUNCE_CYCLES disagreeing samples; a rising flip is a press
  always_comb begin
    stab_d = stab_q;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (raw[i] == stab_q[i]) ? '0 : cnt_q[i] + 1'b1;
      if (raw[i] != stab_q[i] && cnt_q[i] == D_LAST) begin
        stab_d[i] = raw[i];
        cnt_d[i] = '0;
        press[i] = raw[i];
      end
    end
  end
  // game FSM next state, counters and registered output values
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    wave_d = wave_q;
    pend_d = pend_q;
    new_game_d = 1'b0;
    new_wave_d = 1'b0;
    timer_d = (state_q == S_INTER || state_q == S_OVER) ? ((timer_q == T_SAT) ? timer_q : timer_q + 1'b1) : '0;
    case (state_q)
      S_IDLE: if (start_p) begin
        state_d = S_PLAY;
        new_game_d = 1'b1;
        lives_d = 2'(LIVES_INIT);
        wave_d = 4'd1;
        pend_d = 1'b0;
      end
      S_PLAY: begin
        if (game_status[2]) begin
          state_d = S_OVER;
          lives_d = '0;
        end else if (game_status[0]) begin
          state_d = (lives_q <= 2'd1) ? S_OVER : S_INTER;
          lives_d = (lives_q <= 2'd1) ? 2'd0 : lives_q - 2'd1;
        end else if (game_status[1]) begin
          state_d = S_INTER;
          pend_d = 1'b1;
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: if (start_p || pause_p) state_d = S_PLAY;
      S_INTER: if (timer_q == T_INT) begin
        state_d = S_PLAY;
        if (pend_q) begin
          wave_d = (wave_q >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : wave_q + 4'd1;
          new_wave_d = 1'b1;
          pend_d = 1'b0;
        end
      end
      S_OVER: begin
        if (start_p && timer_q >= T_MIN) begin
          state_d = S_PLAY;
          new_game_d = 1'b1;
          lives_d = 2'(LIVES_INIT);
          wave_d = 4'd1;
          pend_d = 1'b0;
        end else if (timer_q == T_OUT) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    game_state_d = (state_d == S_IDLE) ? 3'b000 : (state_d == S_PLAY) ? 3'b001 : (state_d == S_OVER) ? 3'b011 : 3'b010;
    interlude_d = (state_d == S_INTER);
  end
  // all state and outputs registered together; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      stab_q <= '0;
      cnt_q <= '0;
      game_state_q <= 3'b000;
      interlude_q <= 1'b0;
      new_game_q <= 1'b0;
      new_wave_q <= 1'b0;
      pend_q <= 1'b0;
      lives_q <= '0;
      wave_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stab_q <= stab_d;
      cnt_q <= cnt_d;
      game_state_q <= game_state_d;
      interlude_q <= interlude_d;
      new_game_q <= new_game_d;
      new_wave_q <= new_wave_d;
      pend_q <= pend_d;
      lives_q <= lives_d;
      wave_q <= wave_d;
    end
  end
  assign game_state = game_state_q;
  assign interlude = interlude_q;
  assign new_game = new_game_q;
  assign new_wave = new_wave_q;
  assign lives = lives_q;
  assign wave = wave_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed stimulus, per-cycle behavioural model compare plus literal spot checks
module tb_game_flow_ctrl;
  localparam int DEB = 4, INTER_C = 10, OVER_MIN = 5, OVER_TO = 20;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_INTER = 3, M_OVER = 4;
  logic clk = 0, rst_n = 0;
  logic [4:0] buttons = '0;
  logic [2:0] game_status = '0;
  logic [2:0] game_state;
  logic interlude, new_game, new_wave;
  logic [1:0] lives;
  logic [3:0] wave;
  int n_chk = 0, n_pass = 0;
  game_flow_ctrl #(.DEBOUNCE_CYCLES(DEB), .INTERLUDE_CYCLES(INTER_C), .OVER_MIN_CYCLES(OVER_MIN),
                   .OVER_TIMEOUT_CYCLES(OVER_TO), .LIVES_INIT(3), .MAX_WAVE(15)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .game_status(game_status), .game_state(game_state),
    .interlude(interlude), .new_game(new_game), .new_wave(new_wave), .lives(lives), .wave(wave));
  always #5 clk = ~clk;
  int m_mode = 0, m_t = 0, m_lives = 0, m_wave = 0, nm = 0;
  bit m_pend = 0, m_ng = 0, m_nw = 0, armed = 0, raw = 0;
  bit stab [2] = '{0, 0};
  int run [2] = '{0, 0};
  bit prs [2] = '{0, 0};
  // model: mode + time spent in mode, updated from the same inputs the DUT samples
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_t = 0; m_lives = 0; m_wave = 0; m_pend = 0; m_ng = 0; m_nw = 0;
      stab = '{0, 0}; run = '{0, 0}; armed = 1;
    end else begin
      prs = '{0, 0};
      for (int i = 0; i < 2; i++) begin
        raw = (i == 0) ? buttons[1] : buttons[3];
        if (raw == stab[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == DEB) begin stab[i] = raw; run[i] = 0; prs[i] = raw; end
        end
      end
      nm = m_mode; m_ng = 0; m_nw = 0;
      case (m_mode)
        M_IDLE: if (prs[0]) begin nm = M_PLAY; m_ng = 1; m_lives = 3; m_wave = 1; m_pend = 0; end
        M_PLAY:
          if (game_status[2]) begin nm = M_OVER; m_lives = 0; end
          else if (game_status[0]) begin
            if (m_lives <= 1) begin nm = M_OVER; m_lives = 0; end
            else begin nm = M_INTER; m_lives = m_lives - 1; end
          end
          else if (game_status[1]) begin nm = M_INTER; m_pend = 1; end
          else if (prs[1]) nm = M_PAUSE;
        M_PAUSE: if (prs[0] || prs[1]) nm = M_PLAY;
        M_INTER: if (m_t + 1 == INTER_C) begin
          nm = M_PLAY;
          if (m_pend) begin m_wave = (m_wave < 15) ? m_wave + 1 : 15; m_nw = 1; m_pend = 0; end
        end
        M_OVER:
          if (prs[0] && m_t >= OVER_MIN) begin nm = M_PLAY; m_ng = 1; m_lives = 3; m_wave = 1; m_pend = 0; end
          else if (m_t + 1 == OVER_TO) nm = M_IDLE;
        default: nm = M_IDLE;
      endcase
      m_t = (nm == m_mode) ? m_t + 1 : 0;
      m_mode = nm;
    end
  end
  // compare DUT against model every cycle, away from the active edge
  always @(negedge clk) if (armed) begin
    logic [12:0] act, exp;
    act = {game_state, interlude, new_game, new_wave, lives, wave};
    exp = {(m_mode == M_IDLE) ? 3'b000 : (m_mode == M_PLAY) ? 3'b001 : (m_mode == M_OVER) ? 3'b011 : 3'b010,
           m_mode == M_INTER, m_ng, m_nw, 2'(m_lives), 4'(m_wave)};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL model t=%0t got gs=%b il=%b ng=%b nw=%b lives=%0d wave=%0d, want %b", $time,
                  game_state, interlude, new_game, new_wave, lives, wave, exp);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d", name, act, exp);
  endtask
  task automatic press(input int bit_idx);
    buttons[bit_idx] = 1'b1; tick(DEB + 2);
    buttons[bit_idx] = 1'b0; tick(DEB + 2);
  endtask
  task automatic status_pulse(input logic [2:0] s);
    game_status = s; tick(1); game_status = '0;
  endtask
  initial begin
    tick(2); rst_n = 1;
    chk("reset_gs", game_state, 0); chk("reset_lives", lives, 0); chk("reset_wave", wave, 0);
    buttons[1] = 1; tick(3); buttons[1] = 0; tick(5);
    chk("glitch_idle", game_state, 0);
    buttons[1] = 1; tick(4);
    chk("start_gs", game_state, 1); chk("start_ng", new_game, 1); chk("start_lives", lives, 3); chk("start_wave", wave, 1);
    tick(1); chk("ng_once", new_game, 0);
    tick(1); buttons[1] = 0; tick(6);
    status_pulse(3'b010);
    chk("clr_gs", game_state, 2); chk("clr_il", interlude, 1);
    tick(9); chk("inter_hold", game_state, 2);
    tick(1); chk("inter_end_gs", game_state, 1); chk("inter_nw", new_wave, 1); chk("inter_wave", wave, 2);
    tick(1); chk("nw_once", new_wave, 0);
    buttons[3] = 1; tick(4);
    chk("pause_gs", game_state, 2); chk("pause_il", interlude, 0);
    tick(2); buttons[3] = 0; tick(6);
    game_status = 3'b001; tick(3); game_status = '0;
    chk("pause_ign_gs", game_state, 2); chk("pause_ign_lives", lives, 3);
    buttons[3] = 1; tick(4);
    chk("resume_gs", game_state, 1); chk("resume_lives", lives, 3);
    tick(2); buttons[3] = 0; tick(6);
    status_pulse(3'b001); tick(10);
    status_pulse(3'b001); tick(10);
    chk("hit_lives", lives, 1); chk("hit_gs", game_state, 1);
    status_pulse(3'b011);
    chk("last_gs", game_state, 3); chk("last_lives", lives, 0); chk("last_wave", wave, 2); chk("last_il", interlude, 0);
    buttons[1] = 1; tick(4);
    chk("over_early", game_state, 3);
    tick(2); buttons[1] = 0; tick(4);
    buttons[1] = 1; tick(4);
    chk("over_start_gs", game_state, 1); chk("over_start_ng", new_game, 1);
    chk("over_start_lives", lives, 3); chk("over_start_wave", wave, 1);
    tick(2); buttons[1] = 0; tick(6);
    status_pulse(3'b100);
    chk("land_gs", game_state, 3); chk("land_lives", lives, 0);
    tick(19); chk("to_hold", game_state, 3);
    tick(1); chk("to_idle", game_state, 0);
    press(1);
    status_pulse(3'b010); tick(3);
    rst_n = 0; tick(1);
    chk("rst_gs", game_state, 0); chk("rst_lives", lives, 0); chk("rst_wave", wave, 0);
    chk("rst_pulses", {new_game, new_wave, interlude}, 0);
    rst_n = 1; tick(2);
    press(1);
    for (int k = 0; k < 15; k++) begin status_pulse(3'b010); tick(10); end
    chk("wave_sat", wave, 15);
    status_pulse(3'b110);
    chk("illegal_gs", game_state, 3); chk("illegal_lives", lives, 0);
    tick(2);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
